// File: rtl/ux607_deglitch_pkg.sv
// Shared sizing constants, channel state encoding and the limit helper for the
// ux607 input deglitch controller.
package ux607_deglitch_pkg;

  localparam int NCH_DEF   = 8;
  localparam int CNT_W_DEF = 8;
  localparam int NCH_MAX   = 32;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } chan_state_e;

  // A programmed limit of zero behaves like one so a change is never accepted without a tick.
  function automatic logic [31:0] eff_limit(input logic [31:0] lim);
    eff_limit = (lim == 32'd0) ? 32'd1 : lim;
  endfunction

endpackage

// File: rtl/ux607_deglitch_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, filtered level
// and sticky rise/fall pending bits.
module ux607_deglitch_chan
  import ux607_deglitch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pad_in,
  input  logic             sample_tk,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             pend_clr,
  output logic             filt_out,
  output logic             rise_pend,
  output logic             fall_pend
);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             filt_r;
  logic             filt_nxt_s;
  logic             rise_r;
  logic             rise_nxt_s;
  logic             fall_r;
  logic             fall_nxt_s;
  logic             rise_evt_s;
  logic             fall_evt_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic [CNT_W:0]   lim_eff_s;
  chan_state_e      state_s;

  // Extra MSB keeps the increment and compare free of wrap-around.
  assign cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
  assign lim_eff_s = (CNT_W+1)'(eff_limit(32'(cfg_limit)));
  assign state_s   = (sync2_r != filt_r) ? ST_QUAL : ST_STABLE;

  // Next counter/level and edge events from the qualification state.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    filt_nxt_s = filt_r;
    rise_evt_s = 1'b0;
    fall_evt_s = 1'b0;
    if (!cfg_en) begin
      cnt_nxt_s  = {CNT_W{1'b0}};
      filt_nxt_s = 1'b0;
    end else begin
      case (state_s)
        ST_STABLE: begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
        ST_QUAL: begin
          if (sample_tk) begin
            if (cnt_inc_s >= lim_eff_s) begin
              cnt_nxt_s  = {CNT_W{1'b0}};
              filt_nxt_s = sync2_r;
              rise_evt_s = sync2_r;
              fall_evt_s = ~sync2_r;
            end else if (cnt_inc_s[CNT_W]) begin
              cnt_nxt_s = {CNT_W{1'b1}};
            end else begin
              cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
            end
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // A new event on the same cycle as a clear keeps the pending bit set.
  always_comb begin
    rise_nxt_s = (rise_r & ~pend_clr) | rise_evt_s;
    fall_nxt_s = (fall_r & ~pend_clr) | fall_evt_s;
  end

  // Synchroniser, counter, filtered level and pending registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      filt_r  <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= pad_in;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_nxt_s;
      filt_r  <= filt_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
    end
  end

  assign filt_out  = filt_r;
  assign rise_pend = rise_r;
  assign fall_pend = fall_r;

endmodule

// File: rtl/ux607_deglitch_ctrl.sv
// Multi-channel input debounce controller: NCH independent deglitch channels and
// one registered aggregate interrupt.
module ux607_deglitch_ctrl
  import ux607_deglitch_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   pad_in,
  input  logic             sample_tk,
  input  logic [NCH-1:0]   cfg_en,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic [NCH-1:0]   cfg_rie,
  input  logic [NCH-1:0]   cfg_fie,
  input  logic [NCH-1:0]   pend_clr,
  output logic [NCH-1:0]   filt_out,
  output logic [NCH-1:0]   rise_pend,
  output logic [NCH-1:0]   fall_pend,
  output logic             irq
);

  logic irq_r;
  logic irq_nxt_s;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ux607_deglitch_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .pad_in    (pad_in[i]),
      .sample_tk (sample_tk),
      .cfg_en    (cfg_en[i]),
      .cfg_limit (cfg_limit),
      .pend_clr  (pend_clr[i]),
      .filt_out  (filt_out[i]),
      .rise_pend (rise_pend[i]),
      .fall_pend (fall_pend[i])
    );
  end

  // Interrupt request from enabled pending bits.
  always_comb begin
    irq_nxt_s = |((rise_pend & cfg_rie) | (fall_pend & cfg_fie));
  end

  // Aggregate interrupt register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_nxt_s;
    end
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_ux607_deglitch_ctrl.sv
// Self-checking bench for ux607_deglitch_ctrl: a vector table plus hand-built
// sequences, expected outputs queued at drive time and popped after each edge.
module tb_ux607_deglitch_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] pad_in;
  logic       sample_tk;
  logic [7:0] cfg_en;
  logic [7:0] cfg_limit;
  logic [7:0] cfg_rie;
  logic [7:0] cfg_fie;
  logic [7:0] pend_clr;
  logic [7:0] filt_out;
  logic [7:0] rise_pend;
  logic [7:0] fall_pend;
  logic       irq;

  typedef struct packed {
    logic [7:0] pad;
    logic       tk;
    logic [7:0] en;
    logic [7:0] lim;
    logic [7:0] fie;
    logic [7:0] clr;
    logic [7:0] xf;
    logic [7:0] xr;
    logic [7:0] xfa;
    logic       xi;
  } vec_t;

  typedef struct packed {
    logic [7:0] f;
    logic [7:0] r;
    logic [7:0] fa;
    logic       i;
  } exp_t;

  exp_t sbq[$];
  int   tagq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[19];

  always #5 clock = ~clock;

  ux607_deglitch_ctrl #(
    .NCH   (8),
    .CNT_W (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pad_in    (pad_in),
    .sample_tk (sample_tk),
    .cfg_en    (cfg_en),
    .cfg_limit (cfg_limit),
    .cfg_rie   (cfg_rie),
    .cfg_fie   (cfg_fie),
    .pend_clr  (pend_clr),
    .filt_out  (filt_out),
    .rise_pend (rise_pend),
    .fall_pend (fall_pend),
    .irq       (irq)
  );

  function automatic vec_t mk(input logic [7:0] pad, input logic tk, input logic [7:0] en,
                              input logic [7:0] lim, input logic [7:0] fie, input logic [7:0] clr,
                              input logic [7:0] xf, input logic [7:0] xr, input logic [7:0] xfa,
                              input logic xi);
    vec_t v;
    v.pad = pad; v.tk = tk; v.en = en; v.lim = lim; v.fie = fie; v.clr = clr;
    v.xf = xf; v.xr = xr; v.xfa = xfa; v.xi = xi;
    return v;
  endfunction

  task automatic step(input vec_t v, input int tag);
    exp_t e;
    exp_t a;
    int   t;
    @(negedge clock);
    pad_in    = v.pad;
    sample_tk = v.tk;
    cfg_en    = v.en;
    cfg_limit = v.lim;
    cfg_fie   = v.fie;
    pend_clr  = v.clr;
    sbq.push_back({v.xf, v.xr, v.xfa, v.xi});
    tagq.push_back(tag);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    t = tagq.pop_front();
    a = {filt_out, rise_pend, fall_pend, irq};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL step_%0d: got filt=%h rise=%h fall=%h irq=%b, want filt=%h rise=%h fall=%h irq=%b",
               t, a.f, a.r, a.fa, a.i, e.f, e.r, e.fa, e.i);
    end
  endtask

  task automatic check_zero(input int tag);
    n_cmp++;
    if ({filt_out, rise_pend, fall_pend, irq} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_%0d: got filt=%h rise=%h fall=%h irq=%b, want all 0",
               tag, filt_out, rise_pend, fall_pend, irq);
    end
  endtask

  // limit=4, one tick every 4 clocks, pad held high: accepted on the 4th tick (step 15)
  task automatic run_accept4(input int base);
    for (int i = 0; i < 20; i++) begin
      step(mk(8'hff, 1'((i % 4) == 3), 8'hff, 8'd4, 8'hff, 8'h00,
              (i >= 15) ? 8'hff : 8'h00, (i >= 15) ? 8'hff : 8'h00, 8'h00, 1'(i >= 16)), base + i);
    end
  endtask

  initial begin
    reset     = 1'b0;
    pad_in    = 8'h00;
    sample_tk = 1'b0;
    cfg_en    = 8'hff;
    cfg_limit = 8'd1;
    cfg_rie   = 8'hff;
    cfg_fie   = 8'hff;
    pend_clr  = 8'h00;

    //              pad    tk    en     lim   fie    clr     filt   rise   fall  irq
    tbl[0]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[1]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[2]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b0);
    tbl[3]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b1);
    tbl[4]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 1'b1);
    tbl[5]  = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'h00, 8'h00, 1'b0);
    tbl[6]  = mk(8'h00, 1'b1, 8'hff, 8'd0, 8'hff, 8'h00, 8'hff, 8'h00, 8'h00, 1'b0);
    tbl[7]  = mk(8'h00, 1'b1, 8'hff, 8'd0, 8'hff, 8'h00, 8'hff, 8'h00, 8'h00, 1'b0);
    tbl[8]  = mk(8'h00, 1'b1, 8'hff, 8'd0, 8'hff, 8'h00, 8'h00, 8'h00, 8'hff, 1'b0);
    tbl[9]  = mk(8'h00, 1'b1, 8'hff, 8'd0, 8'hff, 8'h00, 8'h00, 8'h00, 8'hff, 1'b1);
    tbl[10] = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 1'b1);
    tbl[11] = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[12] = mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b0);
    tbl[13] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b1);
    tbl[14] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b1);
    tbl[15] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'hff, 8'hff, 8'h00, 8'h00, 8'hff, 1'b1);
    tbl[16] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 1'b0);
    tbl[17] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'h00, 8'hff, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[18] = mk(8'h00, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    repeat (2) @(negedge clock);
    #1;
    check_zero(0);
    @(negedge clock);
    reset = 1'b1;

    // limit 1 and 0 with tick tied high, clear/set collision, interrupt masking
    for (int i = 0; i < 19; i++) begin
      step(tbl[i], 100 + i);
    end

    // pad high for only 3 ticks: rejected, nothing pending
    for (int i = 0; i < 20; i++) begin
      step(mk((i < 12) ? 8'hff : 8'h00, 1'((i % 4) == 3), 8'hff, 8'd4, 8'hff, 8'h00,
              8'h00, 8'h00, 8'h00, 1'b0), 200 + i);
    end

    // full acceptance also proves the counter restarted from zero
    run_accept4(300);

    // fall qualification in progress (3 ticks counted), then async reset
    for (int i = 0; i < 12; i++) begin
      step(mk(8'h00, 1'((i % 4) == 3), 8'hff, 8'd4, 8'hff, 8'h00,
              8'hff, 8'hff, 8'h00, 1'b1), 400 + i);
    end
    @(negedge clock);
    reset  = 1'b0;
    pad_in = 8'hff;
    #1;
    check_zero(1);
    @(negedge clock);
    reset = 1'b1;
    run_accept4(500);

    // disable odd channels: level forced low, pending kept, no fall event
    step(mk(8'hff, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'hff, 8'h00, 1'b1), 600);
    step(mk(8'hff, 1'b1, 8'h55, 8'd1, 8'hff, 8'h00, 8'h55, 8'hff, 8'h00, 1'b1), 601);
    step(mk(8'hff, 1'b1, 8'h55, 8'd1, 8'hff, 8'hff, 8'h55, 8'h00, 8'h00, 1'b1), 602);
    step(mk(8'hff, 1'b1, 8'h55, 8'd1, 8'hff, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0), 603);
    // re-enable with pad high, limit 2: rise on the second tick
    step(mk(8'hff, 1'b0, 8'hff, 8'd2, 8'hff, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0), 604);
    step(mk(8'hff, 1'b1, 8'hff, 8'd2, 8'hff, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0), 605);
    step(mk(8'hff, 1'b0, 8'hff, 8'd2, 8'hff, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0), 606);
    step(mk(8'hff, 1'b1, 8'hff, 8'd2, 8'hff, 8'h00, 8'hff, 8'haa, 8'h00, 1'b0), 607);
    step(mk(8'hff, 1'b0, 8'hff, 8'd2, 8'hff, 8'h00, 8'hff, 8'haa, 8'h00, 1'b1), 608);
    // mixed per-channel levels
    step(mk(8'h0f, 1'b1, 8'hff, 8'd1, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 1'b1), 609);
    step(mk(8'h0f, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'hff, 8'h00, 8'h00, 1'b0), 610);
    step(mk(8'h0f, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h0f, 8'h00, 8'hf0, 1'b0), 611);
    step(mk(8'h0f, 1'b1, 8'hff, 8'd1, 8'hff, 8'h00, 8'h0f, 8'h00, 8'hf0, 1'b1), 612);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
